decode_stage: RTL and testbench
===============================

# decode_stage

Registered, flow-controlled RV32I decode stage sitting between fetch and execute. Accepts fetched (pc, instruction) pairs over a valid/ready handshake and buffers them in a parametrised skid FIFO. Decodes the head entry into the control bundle used by the ALU, memory and CSR paths and holds it in an output register. Adds flush, back-pressure, CSR-immediate (zimm) handling and optional illegal-instruction detection.

## Interface
- DEPTH, 2: input FIFO entries; power of two, ≥2.
- PC_W, 32: PC width.

- clk  in  1  stage clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered and output entries.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  stage can accept; equals !fifo_full && !reset.
- in_pc  in  PC_W  PC of offered instruction.
- in_instr  in  32  raw instruction (rv32i_inst_u).
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes bundle.
- out_pc, out_instr  out  PC_W/32  passthrough of the decoded entry.
- out_rs1, out_rs2, out_rd  out  5  register indices; 0 when unused.
- out_imm  out  32  immediate; for CSRRWI/CSRRSI/CSRRCI it is the zero-extended rs1 field (zimm).
- out_csr_addr  out  12  instr[31:20] for SYSTEM, else 0.
- out_funct3  out  3  memory access size/sign.
- out_alu_op, out_alu_input1_type, out_alu_input2_type, out_wb_from, out_r_we, out_mem_op, out_csr_we  out  enum  control bundle from rv32i package.
- out_illegal  out  1  entry is an illegal encoding.

## Operation
- Accept on in_valid && in_ready; consume on out_valid && out_ready.
- Output register loads when empty or consumed in the same cycle:
  - FIFO non-empty: loads decoded FIFO head; accepted input (if any) enqueues.
  - FIFO empty: accepted input bypasses the FIFO and decodes straight into the output register.
- Order strictly preserved; FIFO pointers are log2(DEPTH)+1 bits, full/empty by MSB compare; wrap-around by natural overflow.
- Decode per RV32I base encoding. CSRRCI selects CSR/IMM inputs, with imm = zimm.
- FENCE, ECALL and EBREAK produce no register or CSR write.
- flush: FIFO cleared and out_valid cleared next cycle. in_valid and out_ready are ignored in the flush cycle; nothing is accepted or consumed.
- reset overrides flush; reset mid-stream drops all entries.

## Timing
- Reset values: out_valid=0, in_ready=0 during reset and 1 the cycle after; all out_* data fields 0 and enums at encoding 0; FIFO empty.
- Latency: accept at cycle N into an empty stage gives out_valid at N+1.
- Throughput: 1 entry/cycle sustained with out_ready held high.
- Full FIFO plus stalled output: in_ready=0; the offered entry must be held by fetch.
- Simultaneous accept and consume at occupancy DEPTH: no acceptance, since in_ready derives only from full (no combinational ready path from out_ready).
- out_* stable while out_valid && !out_ready.

## Configuration
- RV32I_DECODE_ILLEGAL_EN defined: out_illegal asserted for any of:
  - instr[1:0] != 2'b11 or unknown opcode;
  - BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 ≥011;
  - OP funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101;
  - SLLI imm[11:5]≠0; SRLI/SRAI imm[11:5] not 0x00/0x20; SYSTEM funct3 100.
- When out_illegal is asserted, the bundle is forced to ALU_NOP, WB_NONE, REG_WD (both r_we and csr_we), MEM_LOAD.
- Macro undefined: out_illegal tied 0. Reserved encodings decode as the nearest defined instruction; unknown opcode still forces the NOP bundle.

## Structure
- rv32i package: add decode_bundle_t (packed struct of all out_* decode fields) and function decode_inst(rv32i_inst_u) returning it. Existing enums reused unchanged.
- Sub-module: inst_fifo (parametrised DEPTH, payload {pc, instr}, sync reset, clear input driven by flush).
- decode_stage is top: handshake, bypass mux, output register.

## Test plan
- Single ADDI x1,x2,-1 (0xFFF10093) into an idle stage at cycle 0 -> out_valid at 1, rs1=2, rd=1, imm=0xFFFFFFFF, ALU_ADD, REG_WE.
- out_ready=0 while streaming 4 instrs at DEPTH=2 -> in_ready drops after 3 accepted (2 FIFO + 1 output). Release -> 4 bundles out in order, no loss or duplicates.
- CSRRCI x5,0x300,7 (0x3003F2F3) -> csr_addr=0x300, imm=7, alu_input2_type=ALU_INPUT2_IMM, csr_we=REG_WE.
- flush with FIFO full and out_valid=1 -> next cycle out_valid=0, in_ready=1; the next accepted instr emerges 1 cycle later.
- With RV32I_DECODE_ILLEGAL_EN: 0x00000000 and BEQ with funct3=010 -> out_illegal=1, r_we=REG_WD, mem_op=MEM_LOAD. Without the macro, the BRANCH case gives out_illegal=0.
- reset asserted mid-stream with 2 entries buffered -> all outputs at reset values next cycle; in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// RV32I decode types, control-bundle enums and the combinational decoder.
// RV32I_DECODE_ILLEGAL_EN enables illegal-encoding detection in decode_inst.
package decode_stage_pkg;

    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
        ALU_CSRRW, ALU_CSRRS, ALU_CSRRC
    } alu_op_e;

    typedef enum logic [1:0] {
        ALU_INPUT1_RS1, ALU_INPUT1_PC, ALU_INPUT1_ZERO, ALU_INPUT1_CSR
    } alu_input1_type_e;

    typedef enum logic [1:0] {
        ALU_INPUT2_RS2, ALU_INPUT2_IMM, ALU_INPUT2_FOUR, ALU_INPUT2_RS1
    } alu_input2_type_e;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_CSR} wb_from_e;
    typedef enum logic {REG_WD, REG_WE} reg_we_e;
    typedef enum logic {MEM_LOAD, MEM_STORE} mem_op_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef union packed {
        logic [31:0] raw;
        r_type_t     r;
    } rv32i_inst_u;

    typedef struct packed {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [31:0]      imm;
        logic [11:0]      csr_addr;
        logic [2:0]       funct3;
        alu_op_e          alu_op;
        alu_input1_type_e alu_input1_type;
        alu_input2_type_e alu_input2_type;
        wb_from_e         wb_from;
        reg_we_e          r_we;
        mem_op_e          mem_op;
        reg_we_e          csr_we;
        logic             illegal;
    } decode_bundle_t;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    // alt selects SUB for funct3 000 and SRA for funct3 101.
    function automatic alu_op_e alu_from_f3(logic [2:0] f3, logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Reserved branch funct3 010/011 fold onto BEQ/BNE.
    function automatic alu_op_e branch_op(logic [2:0] f3);
        case (f3)
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            3'b111:  return ALU_BGEU;
            default: return f3[0] ? ALU_BNE : ALU_BEQ;
        endcase
    endfunction

    function automatic logic is_illegal(rv32i_inst_u inst);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = inst.r.funct3;
        f7 = inst.r.funct7;
        case (inst.r.opcode)
            OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcMiscMem: return 1'b0;
            OpcBranch: return f3[2:1] == 2'b01;
            OpcLoad:   return f3 == 3'b011 || f3[2:1] == 2'b11;
            OpcStore:  return f3 >= 3'b011;
            OpcOpImm:  return (f3 == 3'b001 && f7 != 7'h00) ||
                              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            OpcOp:     return (f7 != 7'h00 && f7 != 7'h20) ||
                              (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
            OpcSystem: return f3 == 3'b100;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic decode_bundle_t decode_inst(rv32i_inst_u inst);
        decode_bundle_t b;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [2:0]  f3;
        b     = '0;
        f3    = inst.r.funct3;
        imm_i = {{20{inst.raw[31]}}, inst.raw[31:20]};
        imm_s = {{20{inst.raw[31]}}, inst.raw[31:25], inst.raw[11:7]};
        imm_b = {{20{inst.raw[31]}}, inst.raw[7], inst.raw[30:25], inst.raw[11:8], 1'b0};
        imm_u = {inst.raw[31:12], 12'h000};
        imm_j = {{12{inst.raw[31]}}, inst.raw[19:12], inst.raw[20], inst.raw[30:21], 1'b0};
        case (inst.r.opcode)
            OpcLui, OpcAuipc: begin
                b.rd              = inst.r.rd;
                b.imm             = imm_u;
                b.alu_op          = ALU_ADD;
                b.alu_input1_type = (inst.r.opcode == OpcLui) ? ALU_INPUT1_ZERO : ALU_INPUT1_PC;
                b.alu_input2_type = ALU_INPUT2_IMM;
                b.wb_from         = WB_ALU;
                b.r_we            = REG_WE;
            end
            OpcJal, OpcJalr: begin
                b.rd              = inst.r.rd;
                b.alu_op          = ALU_ADD;
                b.alu_input1_type = ALU_INPUT1_PC;
                b.alu_input2_type = ALU_INPUT2_FOUR;
                b.wb_from         = WB_ALU;
                b.r_we            = REG_WE;
                if (inst.r.opcode == OpcJal) begin
                    b.imm = imm_j;
                end else begin
                    b.imm = imm_i;
                    b.rs1 = inst.r.rs1;
                end
            end
            OpcBranch: begin
                b.rs1    = inst.r.rs1;
                b.rs2    = inst.r.rs2;
                b.imm    = imm_b;
                b.alu_op = branch_op(f3);
            end
            OpcLoad, OpcStore: begin
                b.rs1             = inst.r.rs1;
                b.funct3          = f3;
                b.alu_op          = ALU_ADD;
                b.alu_input2_type = ALU_INPUT2_IMM;
                if (inst.r.opcode == OpcLoad) begin
                    b.rd      = inst.r.rd;
                    b.imm     = imm_i;
                    b.wb_from = WB_MEM;
                    b.r_we    = REG_WE;
                end else begin
                    b.rs2    = inst.r.rs2;
                    b.imm    = imm_s;
                    b.mem_op = MEM_STORE;
                end
            end
            OpcOpImm: begin
                b.rd              = inst.r.rd;
                b.rs1             = inst.r.rs1;
                b.imm             = imm_i;
                b.alu_op          = alu_from_f3(f3, inst.raw[30] && f3 == 3'b101);
                b.alu_input2_type = ALU_INPUT2_IMM;
                b.wb_from         = WB_ALU;
                b.r_we            = REG_WE;
            end
            OpcOp: begin
                b.rd      = inst.r.rd;
                b.rs1     = inst.r.rs1;
                b.rs2     = inst.r.rs2;
                b.alu_op  = alu_from_f3(f3, inst.raw[30]);
                b.wb_from = WB_ALU;
                b.r_we    = REG_WE;
            end
            OpcSystem: begin
                b.csr_addr = inst.raw[31:20];
                // funct3[1:0] == 0 covers ECALL/EBREAK and the reserved 100: no writes.
                if (f3[1:0] != 2'b00) begin
                    b.rd              = inst.r.rd;
                    b.alu_op          = (f3[1:0] == 2'b01) ? ALU_CSRRW :
                                        (f3[1:0] == 2'b10) ? ALU_CSRRS : ALU_CSRRC;
                    b.alu_input1_type = ALU_INPUT1_CSR;
                    b.wb_from         = WB_CSR;
                    b.r_we            = REG_WE;
                    b.csr_we          = REG_WE;
                    if (f3[2]) begin
                        b.alu_input2_type = ALU_INPUT2_IMM;
                        b.imm             = {27'd0, inst.r.rs1};
                    end else begin
                        b.alu_input2_type = ALU_INPUT2_RS1;
                        b.rs1             = inst.r.rs1;
                    end
                end
            end
            default: ;
        endcase
`ifdef RV32I_DECODE_ILLEGAL_EN
        if (is_illegal(inst)) begin
            b.illegal = 1'b1;
            b.alu_op  = ALU_NOP;
            b.wb_from = WB_NONE;
            b.r_we    = REG_WD;
            b.csr_we  = REG_WD;
            b.mem_op  = MEM_LOAD;
        end
`else
        b.illegal = 1'b0;
`endif
        return b;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of decode_stage.
// master is the decode stage itself; slave is the fetch/execute environment.
interface decode_stage_if #(
    parameter int unsigned PC_W = 32
);
    import decode_stage_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PC_W-1:0]  in_pc;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [31:0]      out_imm;
    logic [11:0]      out_csr_addr;
    logic [2:0]       out_funct3;
    alu_op_e          out_alu_op;
    alu_input1_type_e out_alu_input1_type;
    alu_input2_type_e out_alu_input2_type;
    wb_from_e         out_wb_from;
    reg_we_e          out_r_we;
    mem_op_e          out_mem_op;
    reg_we_e          out_csr_we;
    logic             out_illegal;

    modport master (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd, out_imm,
               out_csr_addr, out_funct3, out_alu_op, out_alu_input1_type,
               out_alu_input2_type, out_wb_from, out_r_we, out_mem_op, out_csr_we, out_illegal
    );

    modport slave (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd, out_imm,
               out_csr_addr, out_funct3, out_alu_op, out_alu_input1_type,
               out_alu_input2_type, out_wb_from, out_r_we, out_mem_op, out_csr_we, out_illegal
    );

endinterface

// File: rtl/decode_stage_inst_fifo.sv
// Power-of-two FIFO for {pc, instr} entries; extra pointer MSB tells full from empty.
module inst_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) wptr_q <= wptr_q + 1'b1;
            if (pop && !empty) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: skid FIFO, empty-FIFO bypass, decoder and registered output bundle.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 32
) (
    input logic            clk,
    input logic            reset,
    input logic            flush,
    decode_stage_if.master bus
);
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [PC_W+31:0]     fifo_head;
    logic                 accept, consume, load_out, have_src;
    logic [PC_W-1:0]      src_pc;
    logic [31:0]          src_instr;
    logic                 out_valid_q;
    logic [PC_W-1:0]      out_pc_q;
    logic [31:0]          out_instr_q;
    decode_bundle_t       out_q;

    // in_ready looks only at FIFO fullness, never at out_ready.
    assign bus.in_ready = !fifo_full && !reset;
    assign accept       = bus.in_valid && bus.in_ready && !flush;
    assign consume      = out_valid_q && bus.out_ready && !flush;
    assign load_out     = !out_valid_q || consume;
    assign have_src     = !fifo_empty || accept;
    assign fifo_pop     = load_out && !fifo_empty && !flush;
    assign fifo_push    = accept && !(load_out && fifo_empty);
    assign {src_pc, src_instr} = fifo_empty ? {bus.in_pc, bus.in_instr} : fifo_head;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + 32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .wdata ({bus.in_pc, bus.in_instr}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= have_src;
            if (have_src) begin
                out_pc_q    <= src_pc;
                out_instr_q <= src_instr;
                out_q       <= decode_inst(src_instr);
            end
        end
    end

    assign bus.out_valid           = out_valid_q;
    assign bus.out_pc              = out_pc_q;
    assign bus.out_instr           = out_instr_q;
    assign bus.out_rs1             = out_q.rs1;
    assign bus.out_rs2             = out_q.rs2;
    assign bus.out_rd              = out_q.rd;
    assign bus.out_imm             = out_q.imm;
    assign bus.out_csr_addr        = out_q.csr_addr;
    assign bus.out_funct3          = out_q.funct3;
    assign bus.out_alu_op          = out_q.alu_op;
    assign bus.out_alu_input1_type = out_q.alu_input1_type;
    assign bus.out_alu_input2_type = out_q.alu_input2_type;
    assign bus.out_wb_from         = out_q.wb_from;
    assign bus.out_r_we            = out_q.r_we;
    assign bus.out_mem_op          = out_q.mem_op;
    assign bus.out_csr_we          = out_q.csr_we;
    assign bus.out_illegal         = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against an occupancy-queue model and a table-driven decoder.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PC_W  = 32;
`ifdef RV32I_DECODE_ILLEGAL_EN
    localparam bit IllegalEn = 1'b1;
`else
    localparam bit IllegalEn = 1'b0;
`endif

    logic clk, reset, flush, acc;
    int   n_checks, n_fail;
    logic [63:0] q [$];

    alu_op_e    op_tab  [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_op_e    br_tab  [8] = '{ALU_BEQ, ALU_BNE, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    alu_op_e    csr_tab [4] = '{ALU_NOP, ALU_CSRRW, ALU_CSRRS, ALU_CSRRC};
    logic [6:0] opcs   [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                                7'h0f, 7'h73};

    decode_stage_if #(.PC_W(PC_W)) bus ();

    decode_stage #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder: format-driven immediates plus funct3 lookup tables.
    function automatic decode_bundle_t ref_decode(input logic [31:0] ins);
        decode_bundle_t d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic        bad;
        d     = '0;
        bad   = 1'b0;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = $signed(ins) >>> 20;
        case (ins[6:0])
            7'h37, 7'h17: begin
                d.rd = ins[11:7]; d.imm = {ins[31:12], 12'h000}; d.alu_op = ALU_ADD;
                d.alu_input1_type = ins[5] ? ALU_INPUT1_ZERO : ALU_INPUT1_PC;
                d.alu_input2_type = ALU_INPUT2_IMM; d.wb_from = WB_ALU; d.r_we = REG_WE;
            end
            7'h6f, 7'h67: begin
                d.rd = ins[11:7]; d.alu_op = ALU_ADD; d.alu_input1_type = ALU_INPUT1_PC;
                d.alu_input2_type = ALU_INPUT2_FOUR; d.wb_from = WB_ALU; d.r_we = REG_WE;
                if (ins[3]) d.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                else begin d.imm = imm_i; d.rs1 = ins[19:15]; end
            end
            7'h63: begin
                d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.alu_op = br_tab[f3];
                d.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'h03: begin
                d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.imm = imm_i; d.alu_op = ALU_ADD;
                d.alu_input2_type = ALU_INPUT2_IMM; d.wb_from = WB_MEM; d.r_we = REG_WE;
                d.mem_op = MEM_LOAD; d.funct3 = f3;
                bad = (f3 == 3'd3) || (f3 >= 3'd6);
            end
            7'h23: begin
                d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.alu_op = ALU_ADD;
                d.imm = (imm_i & ~32'h1f) | {27'd0, ins[11:7]};
                d.alu_input2_type = ALU_INPUT2_IMM; d.mem_op = MEM_STORE; d.funct3 = f3;
                bad = f3 >= 3'd3;
            end
            7'h13: begin
                d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.imm = imm_i;
                d.alu_op = (f3 == 3'd5 && ins[30]) ? ALU_SRA : op_tab[f3];
                d.alu_input2_type = ALU_INPUT2_IMM; d.wb_from = WB_ALU; d.r_we = REG_WE;
                bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h33: begin
                d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
                d.alu_op = (ins[30] && f3 == 3'd0) ? ALU_SUB :
                           (ins[30] && f3 == 3'd5) ? ALU_SRA : op_tab[f3];
                d.wb_from = WB_ALU; d.r_we = REG_WE;
                bad = (f7 != 7'h00 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
            end
            7'h0f: ;
            7'h73: begin
                d.csr_addr = ins[31:20];
                bad = f3 == 3'd4;
                if (f3 != 3'd0 && f3 != 3'd4) begin
                    d.rd = ins[11:7]; d.alu_op = csr_tab[f3[1:0]];
                    d.alu_input1_type = ALU_INPUT1_CSR; d.wb_from = WB_CSR;
                    d.r_we = REG_WE; d.csr_we = REG_WE;
                    if (f3 > 3'd4) begin
                        d.alu_input2_type = ALU_INPUT2_IMM; d.imm = 32'(ins[19:15]);
                    end else begin
                        d.alu_input2_type = ALU_INPUT2_RS1; d.rs1 = ins[19:15];
                    end
                end
            end
            default: bad = 1'b1;
        endcase
        if (IllegalEn && bad) begin
            d.alu_op = ALU_NOP; d.wb_from = WB_NONE; d.r_we = REG_WD;
            d.csr_we = REG_WD; d.mem_op = MEM_LOAD;
        end
        d.illegal = IllegalEn && bad;
        return d;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) return r;
        opc = opcs[$urandom_range(0, 10)];
        if ((opc == 7'h33 || opc == 7'h13) && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {r[31:7], opc};
    endfunction

    // Apply one cycle of inputs, advance the model, then compare at the next falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rst, output logic a);
        decode_bundle_t e;
        bus.in_valid = v; bus.in_pc = pc; bus.in_instr = ins; bus.out_ready = ordy;
        flush = fl; reset = rst;
        a = 1'b0;
        if (rst || fl) q.delete();
        else begin
            a = v && (q.size() < DEPTH + 1);
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (a) q.push_back({pc, ins});
        end
        @(negedge clk);
        check("out_valid", bus.out_valid, q.size() > 0);
        check("in_ready", bus.in_ready, !rst && (q.size() < DEPTH + 1));
        e = rst ? '0 : ref_decode(q.size() > 0 ? q[0][31:0] : 32'd0);
        if (rst || q.size() > 0) begin
            check("pc", bus.out_pc, rst ? 64'd0 : 64'(q[0][63:32]));
            check("instr", bus.out_instr, rst ? 64'd0 : 64'(q[0][31:0]));
            check("regs", {bus.out_rs1, bus.out_rs2, bus.out_rd}, {e.rs1, e.rs2, e.rd});
            check("imm", bus.out_imm, e.imm);
            check("csr_addr", bus.out_csr_addr, e.csr_addr);
            check("funct3", bus.out_funct3, e.funct3);
            check("ctrl", {bus.out_alu_op, bus.out_alu_input1_type, bus.out_alu_input2_type,
                           bus.out_wb_from, bus.out_r_we, bus.out_mem_op, bus.out_csr_we},
                          {e.alu_op, e.alu_input1_type, e.alu_input2_type, e.wb_from, e.r_we,
                           e.mem_op, e.csr_we});
            check("illegal", bus.out_illegal, e.illegal);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    initial begin
        int n_acc, n_out;
        logic pv;
        logic [31:0] ppc, pins, pc_ctr;
        n_checks = 0; n_fail = 0;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        check("rst_in_ready", bus.in_ready, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
        check("post_rst_ready", bus.in_ready, 1'b1);

        // ADDI x1,x2,-1 into an idle stage
        step(1'b1, 32'h100, 32'hFFF10093, 1'b0, 1'b0, 1'b0, acc);
        check("addi_valid", bus.out_valid, 1'b1);
        check("addi_rs1", bus.out_rs1, 5'd2);
        check("addi_rd", bus.out_rd, 5'd1);
        check("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        check("addi_op", bus.out_alu_op, ALU_ADD);
        check("addi_rwe", bus.out_r_we, REG_WE);
        idle(2);

        // Back-pressure: 4 offers with out_ready low, then release
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.in_ready) n_acc++;
            step(1'b1, 32'h200 + 32'(4 * i), 32'h00100093 + (32'(i) << 20), 1'b0, 1'b0, 1'b0,
                 acc);
        end
        check("stall_accepts", n_acc, 3);
        pv = !acc; n_out = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) n_out++;
            step(pv, 32'h20C, 32'h00400093, 1'b1, 1'b0, 1'b0, acc);
            if (acc) pv = 1'b0;
        end
        check("stall_drain", n_out, 4);

        // CSRRCI x5,0x300,7
        step(1'b1, 32'h300, 32'h3003F2F3, 1'b0, 1'b0, 1'b0, acc);
        check("csr_addr_d", bus.out_csr_addr, 12'h300);
        check("csr_imm", bus.out_imm, 32'd7);
        check("csr_in2", bus.out_alu_input2_type, ALU_INPUT2_IMM);
        check("csr_we", bus.out_csr_we, REG_WE);
        idle(2);

        // Flush with FIFO full and output valid
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h400 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h4F0, 32'h00000013, 1'b1, 1'b1, 1'b0, acc);
        check("flush_valid", bus.out_valid, 1'b0);
        check("flush_ready", bus.in_ready, 1'b1);
        step(1'b1, 32'h500, 32'h00A00113, 1'b0, 1'b0, 1'b0, acc);
        check("flush_next_pc", bus.out_pc, 32'h500);
        idle(2);

        // Illegal-encoding cases
        step(1'b1, 32'h600, 32'h00000000, 1'b0, 1'b0, 1'b0, acc);
        check("ill0_flag", bus.out_illegal, IllegalEn);
        check("ill0_rwe", bus.out_r_we, REG_WD);
        check("ill0_mem", bus.out_mem_op, MEM_LOAD);
        idle(1);
        step(1'b1, 32'h604, 32'h00002063, 1'b0, 1'b0, 1'b0, acc);
        check("illbr_flag", bus.out_illegal, IllegalEn);
        check("illbr_rwe", bus.out_r_we, REG_WD);
        idle(2);

        // Reset mid-stream with entries buffered
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h700 + 32'(4 * i), 32'h00100093, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h7F0, 32'h00100093, 1'b1, 1'b0, 1'b1, acc);
        check("mid_rst_valid", bus.out_valid, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
        check("mid_rst_ready", bus.in_ready, 1'b1);

        // Randomized traffic; fetch holds an offer until it is accepted
        pv = 1'b0; ppc = '0; pins = '0; pc_ctr = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            if (!pv && $urandom_range(0, 9) < 7) begin
                pv = 1'b1; ppc = pc_ctr; pins = gen_instr(); pc_ctr += 4;
            end
            step(pv, ppc, pins, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 199) == 0, acc);
            if (acc) pv = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
